mcpu_ctrl: RTL and testbench
============================

# mcpu_ctrl

Multi-cycle MIPS control unit and successor to the single-cycle controller. It runs a Moore-style state machine that issues per-state datapath controls for a shared-memory multi-cycle datapath. Memory accesses handshake with MIO_ready, with an optional wait-state timeout. Compared with the single-cycle decoder it adds I-type arithmetic, bne, lui, jal and jr, plus illegal-opcode and bus-error trapping. It sits between the instruction register and the multi-cycle datapath, in place of the single-cycle controller.

## Interface
- ALU_W, 3, width of ALU_Control.
- TIMEOUT, 16, consecutive MIO_ready=0 cycles tolerated in one memory state before bus error; 0 disables the timeout.
- EN_JAL, 1, 1 enables jal/jr decode; 0 makes them illegal.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- OPcode  in  6  IR[31:26]
- Fun  in  6  IR[5:0]
- MIO_ready  in  1  memory/IO completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegWrite, ALUSrcA, ExtSel, Branch_ne, CPU_MIO  out  1 each
- RegDst, MemtoReg, ALUSrcB, PCSource  out  2 each
- ALU_Control  out  ALU_W
- state  out  4  current state encoding
- illegal_op, bus_err  out  1  sticky trap flags

## Operation
- ALU codes: and 0, or 1, add 2, xor 3, nor 4, srl 5, sub 6, slt 7.
- ALUSrcB: 00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- ExtSel: 1 = zero-extend (andi/ori); otherwise sign-extend.
- PCSource: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A.
- MemtoReg: 00 = ALUOut, 01 = MDR, 10 = imm<<16, 11 = PC.
- RegDst: 00 = rt, 01 = rd, 10 = $31.
- Any control not listed for a state is 0.

States (encoding in brackets):
- IF[0]: MemRead=1, CPU_MIO=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00. IRWrite=PCWrite=MIO_ready. Goes to ID on MIO_ready.
- ID[1]: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Dispatch:
  - lw/sw go to MA.
  - R-type with a supported Fun (add, sub, and, or, xor, nor, slt, srl) goes to RX.
  - jr (R-type, Fun 001000) goes to JR.
  - addi (001000), andi (001100), ori (001101), slti (001010) go to IX.
  - lui (001111) goes to IWB.
  - beq/bne go to BR.
  - j goes to J; jal goes to JAL.
  - Anything else goes to TRAP with illegal_op set.
- MA[2]: ALUSrcA=1, ALUSrcB=10, add. Goes to MR (lw) or MW (sw).
- MR[3]: MemRead=1, CPU_MIO=1, IorD=1. Goes to LWB on MIO_ready.
- LWB[4]: RegWrite=1, RegDst=00, MemtoReg=01. Goes to IF.
- MW[5]: mem_w=1, CPU_MIO=1, IorD=1. Goes to IF on MIO_ready.
- RX[6]: ALUSrcA=1, ALUSrcB=00, ALU_Control from Fun. Goes to RWB.
- RWB[7]: RegWrite=1, RegDst=01, MemtoReg=00. Goes to IF.
- IX[8]: ALUSrcA=1, ALUSrcB=10, ALU_Control add/and/or/slt for addi/andi/ori/slti, ExtSel per opcode. Goes to IWB.
- IWB[9]: RegWrite=1, RegDst=00, MemtoReg=00 (lui: 10). Goes to IF.
- BR[10]: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, Branch_ne=1 for bne. Goes to IF.
- J[11]: PCWrite=1, PCSource=10. Goes to IF.
- JAL[12]: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11. Goes to IF.
- JR[13]: PCWrite=1, PCSource=11. Goes to IF.
- TRAP[15]: all enables 0. Held until rst.

Timeout and trap flags:
- A wait counter of width clog2(TIMEOUT+1) counts cycles with MIO_ready=0 in IF, MR or MW. It clears on state change and on MIO_ready=1.
- When the counter reaches TIMEOUT (TIMEOUT>0), the next state is TRAP and bus_err is set.
- illegal_op and bus_err are sticky until rst.

## Timing
- Reset (async):
  - state=IF, counter=0, illegal_op=bus_err=0.
  - While rst=1, PCWrite, IRWrite, RegWrite, mem_w and PCWriteCond are forced to 0.
  - Other outputs take their IF values.
- Latency with zero wait states, in cycles: R-type/I-type 4, lui 3, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
- Each MIO_ready=0 cycle in a memory state adds one cycle.
- Handshake:
  - mem_w, MemRead and CPU_MIO are held stable from state entry until MIO_ready=1.
  - PCWrite/IRWrite in IF are asserted only in the MIO_ready=1 cycle.
  - If MIO_ready=1 in the same cycle the counter reaches TIMEOUT, the access completes normally; no trap.
- OPcode/Fun are sampled only in ID, RX and IX, and are stable from IR.
- Reset mid-operation returns to IF on the next evaluation. No partial register or memory write is issued.

## Test plan
- Reset, then add (OPcode 0, Fun 100000) with MIO_ready=1: states 0→1→6→7→0. RegWrite=1 with RegDst=01 only in state 7. ALU_Control=2 in state 6.
- lw with MIO_ready low 3 cycles in MR: states 0,1,2,3,3,3,3,4,0. MemRead and IorD held through all four MR cycles.
- bne then beq: BR shows PCWriteCond=1, ALU_Control=6, Branch_ne=1 then 0. Each takes 3 cycles.
- jal with EN_JAL=1: JAL state has RegDst=10, MemtoReg=11, PCWrite=1. Same opcode with EN_JAL=0: state 15, illegal_op=1, all enables 0 until rst.
- TIMEOUT=4, MIO_ready held 0 in IF: TRAP entered after the 4th wait cycle and bus_err=1. Repeat with MIO_ready=1 on the 4th cycle: no trap, goes to ID.
- Assert rst during MW: state=0 immediately, mem_w=0, flags cleared.

Source files
------------

// File: rtl/mcpu_ctrl_if.sv
// mcpu_ctrl_if -- bundle between the multi-cycle control unit and its datapath.
//
// master (controller side): receives OPcode/Fun from the instruction register
//   and MIO_ready from memory/IO. It drives every datapath control, the
//   current state encoding and the sticky trap flags.
// slave (datapath side): the mirror image.
interface mcpu_ctrl_if #(
    parameter int ALU_W = 3
);
    // instruction fields and memory handshake
    logic [5:0]       OPcode;
    logic [5:0]       Fun;
    logic             MIO_ready;

    // single-bit datapath controls
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             mem_w;
    logic             IRWrite;
    logic             RegWrite;
    logic             ALUSrcA;
    logic             ExtSel;
    logic             Branch_ne;
    logic             CPU_MIO;

    // multi-bit datapath selects
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [ALU_W-1:0] ALU_Control;

    // status
    logic [3:0]       state;
    logic             illegal_op;
    logic             bus_err;

    modport master (
        input  OPcode, Fun, MIO_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegWrite,
               ALUSrcA, ExtSel, Branch_ne, CPU_MIO,
               RegDst, MemtoReg, ALUSrcB, PCSource, ALU_Control,
               state, illegal_op, bus_err
    );

    modport slave (
        output OPcode, Fun, MIO_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite, RegWrite,
               ALUSrcA, ExtSel, Branch_ne, CPU_MIO,
               RegDst, MemtoReg, ALUSrcB, PCSource, ALU_Control,
               state, illegal_op, bus_err
    );
endinterface

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl -- Moore-style control unit for the multi-cycle MIPS datapath.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset (returns to IF, clears trap flags)
//   bus  : mcpu_ctrl_if.master. OPcode/Fun from the IR, MIO_ready from memory.
//          It carries all datapath controls, the 4-bit state and the sticky
//          illegal_op/bus_err flags.
//
// Parameters:
//   ALU_W   : width of ALU_Control
//   TIMEOUT : consecutive MIO_ready=0 cycles tolerated in one memory state
//             (IF/MR/MW) before a bus-error trap; 0 disables the timeout
//   EN_JAL  : 1 decodes jal/jr, 0 treats them as illegal opcodes
module mcpu_ctrl #(
    parameter int ALU_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int EN_JAL  = 1
) (
    input  logic        clk,
    input  logic        rst,
    mcpu_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MA   = 4'd2,
        S_MR   = 4'd3,
        S_LWB  = 4'd4,
        S_MW   = 4'd5,
        S_RX   = 4'd6,
        S_RWB  = 4'd7,
        S_IX   = 4'd8,
        S_IWB  = 4'd9,
        S_BR   = 4'd10,
        S_J    = 4'd11,
        S_JAL  = 4'd12,
        S_JR   = 4'd13,
        S_TRAP = 4'd15
    } state_t;

    // opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SRL = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(7);

    // Wait counter sized to hold TIMEOUT; the trap fires on the cycle whose
    // stall would bring the count to TIMEOUT, so a ready in that same cycle
    // still wins.
    localparam int              CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt;
    logic            illegal_q, bus_err_q;
    // Instruction kind captured in ID so later states never look at the IR.
    logic            op_sw, op_lui, op_bne;
    logic            mem_state, wait_hit;

    // raw controls before reset gating
    logic            pc_write, pc_write_cond, ir_write, reg_write, mem_wr;
    logic            iord, mem_read, alu_src_a, ext_sel, branch_ne, cpu_mio;
    logic [1:0]      reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [ALU_W-1:0] alu_ctl;

    assign mem_state = (state_q == S_IF) || (state_q == S_MR) || (state_q == S_MW);
    assign wait_hit  = (TIMEOUT > 0) && mem_state && !bus.MIO_ready &&
                       (wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------
    // State, wait counter and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            op_sw     <= 1'b0;
            op_lui    <= 1'b0;
            op_bne    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_sw  <= (bus.OPcode == OP_SW);
                op_lui <= (bus.OPcode == OP_LUI);
                op_bne <= (bus.OPcode == OP_BNE);
            end
            if ((TIMEOUT == 0) || !mem_state || bus.MIO_ready || (state_d != state_q))
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CW'(1);
            if ((state_q == S_ID) && (state_d == S_TRAP))
                illegal_q <= 1'b1;
            if (wait_hit)
                bus_err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (bus.MIO_ready)  state_d = S_ID;
                else if (wait_hit)  state_d = S_TRAP;
            end
            S_ID: begin
                case (bus.OPcode)
                    OP_RTYPE: begin
                        case (bus.Fun)
                            F_ADD, F_SUB, F_AND, F_OR,
                            F_XOR, F_NOR, F_SLT, F_SRL: state_d = S_RX;
                            F_JR:    state_d = (EN_JAL != 0) ? S_JR : S_TRAP;
                            default: state_d = S_TRAP;
                        endcase
                    end
                    OP_LW, OP_SW:                      state_d = S_MA;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IX;
                    OP_LUI:                            state_d = S_IWB;
                    OP_BEQ, OP_BNE:                    state_d = S_BR;
                    OP_J:                              state_d = S_J;
                    OP_JAL:  state_d = (EN_JAL != 0) ? S_JAL : S_TRAP;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MA: state_d = op_sw ? S_MW : S_MR;
            S_MR: begin
                if (bus.MIO_ready)  state_d = S_LWB;
                else if (wait_hit)  state_d = S_TRAP;
            end
            S_MW: begin
                if (bus.MIO_ready)  state_d = S_IF;
                else if (wait_hit)  state_d = S_TRAP;
            end
            S_RX:   state_d = S_RWB;
            S_IX:   state_d = S_IWB;
            S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR: state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state controls (Moore, except IF's ready-qualified writes)
    // ------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_wr        = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        alu_src_a     = 1'b0;
        ext_sel       = 1'b0;
        branch_ne     = 1'b0;
        cpu_mio       = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_ctl       = ALU_AND;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                cpu_mio   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = ALU_ADD;
                // PC+4 and IR load only once the fetch actually completes
                ir_write  = bus.MIO_ready;
                pc_write  = bus.MIO_ready;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                alu_ctl   = ALU_ADD;
            end
            S_MA: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = ALU_ADD;
            end
            S_MR: begin
                mem_read = 1'b1;
                cpu_mio  = 1'b1;
                iord     = 1'b1;
            end
            S_LWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MW: begin
                mem_wr  = 1'b1;
                cpu_mio = 1'b1;
                iord    = 1'b1;
            end
            S_RX: begin
                alu_src_a = 1'b1;
                case (bus.Fun)
                    F_AND:   alu_ctl = ALU_AND;
                    F_OR:    alu_ctl = ALU_OR;
                    F_XOR:   alu_ctl = ALU_XOR;
                    F_NOR:   alu_ctl = ALU_NOR;
                    F_SRL:   alu_ctl = ALU_SRL;
                    F_SUB:   alu_ctl = ALU_SUB;
                    F_SLT:   alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_IX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (bus.OPcode)
                    OP_ANDI: begin alu_ctl = ALU_AND; ext_sel = 1'b1; end
                    OP_ORI:  begin alu_ctl = ALU_OR;  ext_sel = 1'b1; end
                    OP_SLTI: alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            S_IWB: begin
                reg_write  = 1'b1;
                mem_to_reg = op_lui ? 2'b10 : 2'b00;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_ctl       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = op_bne;
            end
            S_J: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b11;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            default: ;  // TRAP: everything off
        endcase
    end

    // Architectural writes are gated by rst so nothing partial escapes while
    // reset is asserted (IF would otherwise pass MIO_ready straight through).
    assign bus.PCWrite     = pc_write      & ~rst;
    assign bus.PCWriteCond = pc_write_cond & ~rst;
    assign bus.IRWrite     = ir_write      & ~rst;
    assign bus.RegWrite    = reg_write     & ~rst;
    assign bus.mem_w       = mem_wr        & ~rst;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ExtSel      = ext_sel;
    assign bus.Branch_ne   = branch_ne;
    assign bus.CPU_MIO     = cpu_mio;
    assign bus.RegDst      = reg_dst;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.PCSource    = pc_source;
    assign bus.ALU_Control = alu_ctl;
    assign bus.state       = state_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
`timescale 1ns/1ps
module tb_mcpu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] opc, fun;
    logic       rdy;

    int n_checks = 0;
    int n_fail   = 0;

    // three builds: default, jal/jr disabled, short timeout
    mcpu_ctrl_if #(.ALU_W(3)) bus0 ();
    mcpu_ctrl_if #(.ALU_W(3)) bus1 ();
    mcpu_ctrl_if #(.ALU_W(3)) bus2 ();

    assign bus0.OPcode = opc;  assign bus0.Fun = fun;  assign bus0.MIO_ready = rdy;
    assign bus1.OPcode = opc;  assign bus1.Fun = fun;  assign bus1.MIO_ready = rdy;
    assign bus2.OPcode = opc;  assign bus2.Fun = fun;  assign bus2.MIO_ready = rdy;

    mcpu_ctrl #(.ALU_W(3), .TIMEOUT(16), .EN_JAL(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mcpu_ctrl #(.ALU_W(3), .TIMEOUT(16), .EN_JAL(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mcpu_ctrl #(.ALU_W(3), .TIMEOUT(4),  .EN_JAL(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, irw, rw, srca, ext, bne, cmio;
        logic [1:0] rd, m2r, srcb, pcs;
        logic [2:0] alu;
    } ctl_t;

    ctl_t act0;
    assign act0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.IorD, bus0.MemRead, bus0.mem_w,
                   bus0.IRWrite, bus0.RegWrite, bus0.ALUSrcA, bus0.ExtSel, bus0.Branch_ne,
                   bus0.CPU_MIO, bus0.RegDst, bus0.MemtoReg, bus0.ALUSrcB, bus0.PCSource,
                   bus0.ALU_Control};

    // ---------------- reference model ----------------
    function automatic logic [2:0] fun_alu(logic [5:0] f);
        case (f)
            6'b100000: return 3'd2;
            6'b100010: return 3'd6;
            6'b100100: return 3'd0;
            6'b100101: return 3'd1;
            6'b100110: return 3'd3;
            6'b100111: return 3'd4;
            6'b101010: return 3'd7;
            6'b000010: return 3'd5;
            default:   return 3'd2;
        endcase
    endfunction

    // Expected control word for a named state, straight from the state table.
    function automatic ctl_t exp_ctl(int st, logic [5:0] op, logic [5:0] f, logic r);
        ctl_t c = '0;
        case (st)
            0:  begin c.mr = 1; c.cmio = 1; c.srcb = 2'b01; c.alu = 3'd2; c.irw = r; c.pcw = r; end
            1:  begin c.srcb = 2'b11; c.alu = 3'd2; end
            2:  begin c.srca = 1; c.srcb = 2'b10; c.alu = 3'd2; end
            3:  begin c.mr = 1; c.cmio = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 2'b01; end
            5:  begin c.mw = 1; c.cmio = 1; c.iord = 1; end
            6:  begin c.srca = 1; c.alu = fun_alu(f); end
            7:  begin c.rw = 1; c.rd = 2'b01; end
            8:  begin
                    c.srca = 1; c.srcb = 2'b10;
                    case (op)
                        6'b001100: begin c.alu = 3'd0; c.ext = 1; end
                        6'b001101: begin c.alu = 3'd1; c.ext = 1; end
                        6'b001010: c.alu = 3'd7;
                        default:   c.alu = 3'd2;
                    endcase
                end
            9:  begin c.rw = 1; c.m2r = (op == 6'b001111) ? 2'b10 : 2'b00; end
            10: begin c.srca = 1; c.alu = 3'd6; c.pcwc = 1; c.pcs = 2'b01; c.bne = (op == 6'b000101); end
            11: begin c.pcw = 1; c.pcs = 2'b10; end
            12: begin c.pcw = 1; c.pcs = 2'b10; c.rw = 1; c.rd = 2'b10; c.m2r = 2'b11; end
            13: begin c.pcw = 1; c.pcs = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Instruction catalogue: 0-7 R-type ALU, 8 jr, 9-12 I-type ALU, 13 lui,
    // 14 lw, 15 sw, 16 beq, 17 bne, 18 j, 19 jal.
    task automatic get_instr(input int idx, output logic [5:0] op, output logic [5:0] f);
        f  = 6'($urandom);
        op = 6'b000000;
        case (idx)
            0:  f = 6'b100000;  1: f = 6'b100010;  2: f = 6'b100100;  3: f = 6'b100101;
            4:  f = 6'b100110;  5: f = 6'b100111;  6: f = 6'b101010;  7: f = 6'b000010;
            8:  f = 6'b001000;
            9:  op = 6'b001000; 10: op = 6'b001100; 11: op = 6'b001101; 12: op = 6'b001010;
            13: op = 6'b001111; 14: op = 6'b100011; 15: op = 6'b101011;
            16: op = 6'b000100; 17: op = 6'b000101; 18: op = 6'b000010; 19: op = 6'b000011;
            default: op = 6'b000000;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b0;
        #2;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs one instruction on dut0 from IF back to IF: builds the expected
    // state trace (with wif/wmem stall cycles) and compares every cycle.
    task automatic run_instr(input int idx, input int wif, input int wmem);
        int   st_q[$];
        logic rd_q[$];
        logic [5:0] op, f;
        ctl_t e;
        get_instr(idx, op, f);
        for (int i = 0; i < wif; i++) begin st_q.push_back(0); rd_q.push_back(1'b0); end
        st_q.push_back(0); rd_q.push_back(1'b1);
        st_q.push_back(1); rd_q.push_back(1'($urandom));
        if (idx <= 7)       begin st_q.push_back(6); st_q.push_back(7); end
        else if (idx == 8)  st_q.push_back(13);
        else if (idx <= 12) begin st_q.push_back(8); st_q.push_back(9); end
        else if (idx == 13) st_q.push_back(9);
        else if (idx <= 15) st_q.push_back(2);
        else if (idx <= 17) st_q.push_back(10);
        else if (idx == 18) st_q.push_back(11);
        else                st_q.push_back(12);
        while (rd_q.size() < st_q.size()) rd_q.push_back(1'($urandom));
        if (idx == 14 || idx == 15) begin
            for (int i = 0; i < wmem; i++) begin
                st_q.push_back(idx == 14 ? 3 : 5); rd_q.push_back(1'b0);
            end
            st_q.push_back(idx == 14 ? 3 : 5); rd_q.push_back(1'b1);
            if (idx == 14) begin st_q.push_back(4); rd_q.push_back(1'($urandom)); end
        end
        opc = op;
        fun = f;
        for (int c = 0; c < st_q.size(); c++) begin
            rdy = rd_q[c];
            #4;
            e = exp_ctl(st_q[c], op, f, rd_q[c]);
            n_checks++;
            if (bus0.state !== 4'(st_q[c])) begin
                n_fail++;
                $display("FAIL state instr=%0d cyc=%0d got=%0d want=%0d", idx, c, bus0.state, st_q[c]);
            end
            n_checks++;
            if (act0 !== e) begin
                n_fail++;
                $display("FAIL ctl instr=%0d cyc=%0d st=%0d got=%h want=%h", idx, c, st_q[c], act0, e);
            end
            @(posedge clk); #1;
        end
        // back in IF for the next fetch
        n_checks++;
        if (bus0.state !== 4'd0) begin
            n_fail++;
            $display("FAIL return_if instr=%0d got=%0d want=0", idx, bus0.state);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; opc = 6'd0; fun = 6'd0;
        @(posedge clk); #1;
        n_checks++;
        if (bus0.state !== 4'd0 || bus0.illegal_op !== 1'b0 || bus0.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%0d/%b/%b want=0/0/0", bus0.state, bus0.illegal_op, bus0.bus_err);
        end
        n_checks++;
        if (bus0.PCWrite !== 1'b0 || bus0.IRWrite !== 1'b0 || bus0.RegWrite !== 1'b0 ||
            bus0.mem_w !== 1'b0 || bus0.PCWriteCond !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_writes got pcw=%b irw=%b rw=%b mw=%b pcwc=%b want all 0",
                     bus0.PCWrite, bus0.IRWrite, bus0.RegWrite, bus0.mem_w, bus0.PCWriteCond);
        end
        n_checks++;
        if (bus0.MemRead !== 1'b1 || bus0.CPU_MIO !== 1'b1 || bus0.ALUSrcB !== 2'b01 ||
            bus0.ALU_Control !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_if_ctl got mr=%b mio=%b srcb=%b alu=%0d want 1 1 01 2",
                     bus0.MemRead, bus0.CPU_MIO, bus0.ALUSrcB, bus0.ALU_Control);
        end
        rdy = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        do_reset();
        run_instr(0, 0, 0);   // add
        run_instr(7, 1, 0);   // srl with one fetch stall
    endtask

    task automatic test_lw_wait();
        do_reset();
        run_instr(14, 0, 3);
        run_instr(15, 0, 2);
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(17, 0, 0);  // bne
        run_instr(16, 0, 0);  // beq
    endtask

    task automatic test_jal();
        do_reset();
        run_instr(19, 0, 0);
        run_instr(8, 0, 0);   // jr
        run_instr(13, 0, 0);  // lui
        // same jal opcode on the build with jal/jr disabled
        do_reset();
        opc = 6'b000011; fun = 6'd0; rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_checks++;
            if (bus1.state !== 4'd15 || bus1.illegal_op !== 1'b1) begin
                n_fail++;
                $display("FAIL jal_disabled_trap got=%0d/%b want=15/1", bus1.state, bus1.illegal_op);
            end
            n_checks++;
            if (bus1.PCWrite !== 1'b0 || bus1.RegWrite !== 1'b0 || bus1.mem_w !== 1'b0 ||
                bus1.MemRead !== 1'b0 || bus1.IRWrite !== 1'b0 || bus1.CPU_MIO !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_enables got pcw=%b rw=%b mw=%b mr=%b irw=%b mio=%b want all 0",
                         bus1.PCWrite, bus1.RegWrite, bus1.mem_w, bus1.MemRead, bus1.IRWrite, bus1.CPU_MIO);
            end
            rdy = 1'($urandom);
            @(posedge clk); #1;
        end
        do_reset();
        n_checks++;
        if (bus1.illegal_op !== 1'b0 || bus1.state !== 4'd0) begin
            n_fail++;
            $display("FAIL illegal_clear got=%b/%0d want=0/0", bus1.illegal_op, bus1.state);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            n_checks++;
            if (bus2.state !== 4'd0 || bus2.bus_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait cyc=%0d got=%0d/%b want=0/0", c, bus2.state, bus2.bus_err);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus2.state !== 4'd15 || bus2.bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_trap got=%0d/%b want=15/1", bus2.state, bus2.bus_err);
        end
        // ready arriving on the last tolerated cycle completes normally
        do_reset();
        for (int c = 0; c < 4; c++) begin
            rdy = (c == 3);
            @(posedge clk); #1;
        end
        n_checks++;
        if (bus2.state !== 4'd1 || bus2.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_ready_wins got=%0d/%b want=1/0", bus2.state, bus2.bus_err);
        end
    endtask

    task automatic test_reset_mw();
        do_reset();
        opc = 6'b101011; fun = 6'd0;
        rdy = 1'b1; @(posedge clk); #1;   // IF
        rdy = 1'b0; @(posedge clk); #1;   // ID
        @(posedge clk); #1;               // MA
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end  // MW stalls
        n_checks++;
        if (bus0.state !== 4'd5 || bus0.mem_w !== 1'b1 || bus2.bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mw_hold got st=%0d mw=%b err2=%b want 5 1 1", bus0.state, bus0.mem_w, bus2.bus_err);
        end
        rdy = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus0.state !== 4'd0 || bus0.mem_w !== 1'b0 || bus0.PCWrite !== 1'b0 ||
            bus2.bus_err !== 1'b0 || bus2.state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_in_mw got st=%0d mw=%b pcw=%b err2=%b st2=%0d want 0 0 0 0 0",
                     bus0.state, bus0.mem_w, bus0.PCWrite, bus2.bus_err, bus2.state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 60; n++)
            run_instr($urandom_range(0, 19), $urandom_range(0, 3), $urandom_range(0, 3));
        n_checks++;
        if (bus0.illegal_op !== 1'b0 || bus0.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL random_flags got=%b/%b want=0/0", bus0.illegal_op, bus0.bus_err);
        end
    endtask

    initial begin
        opc = 6'd0; fun = 6'd0; rdy = 1'b0;
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jal();
        test_timeout();
        test_reset_mw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
